// File: rtl/tc_mra_req_queue_pkg.sv
// Shared types and defaults for the tile-controller MRA request queue.
// Widths here are the defaults; the RTL modules stay parameterised on them.
package tc_pkg;

   localparam int TC_MRA_NUM_TAGS   = 8;
   localparam int TC_MRA_ADDR_WIDTH = 64;
   localparam int TC_MRA_DATA_WIDTH = 512;
   localparam int TC_MRA_TAG_BITS   = $clog2(TC_MRA_NUM_TAGS);

   typedef logic [TC_MRA_TAG_BITS-1:0] tc_mra_tag_t;

   typedef struct packed {
      logic [TC_MRA_ADDR_WIDTH-1:0] addr;
      logic                         we;
      logic [TC_MRA_DATA_WIDTH-1:0] wdata;
      tc_mra_tag_t                  tag;
   } tc_mra_req_t;

   typedef struct packed {
      logic                         pend;
      logic                         filled;
      logic [TC_MRA_DATA_WIDTH-1:0] data;
   } tc_rob_entry_t;

   function automatic logic [31:0] tc_sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/tc_mra_rob.sv
// Reorder buffer for MRA responses: tag allocation, out-of-order fill, in-order retire.
// Also owns the occupancy count that throttles new requests.
module tc_mra_rob
   import tc_pkg::*;
#(
   parameter  int DATA_WIDTH = TC_MRA_DATA_WIDTH,
   parameter  int NUM_TAGS   = TC_MRA_NUM_TAGS,
   localparam int TAG_BITS   = $clog2(NUM_TAGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_alloc,
   output logic [TAG_BITS-1:0]   o_alloc_ptr,
   input  logic                  i_fill_valid,
   input  logic [TAG_BITS-1:0]   i_fill_tag,
   input  logic [DATA_WIDTH-1:0] i_fill_data,
   output logic                  o_ret_valid,
   output logic [DATA_WIDTH-1:0] o_ret_data,
   output logic [TAG_BITS-1:0]   o_ret_tag,
   input  logic                  i_ret_ready,
   output logic [TAG_BITS:0]     o_occ,
   output logic                  o_full,
   output logic                  o_err
);

   logic [NUM_TAGS-1:0]   r_pend;
   logic [NUM_TAGS-1:0]   r_filled;
   logic [DATA_WIDTH-1:0] r_data [NUM_TAGS];
   logic [TAG_BITS-1:0]   r_alloc_ptr;
   logic [TAG_BITS-1:0]   r_ret_ptr;
   logic [TAG_BITS:0]     r_occ;
   logic                  r_err;

   logic w_fill_ok;
   logic w_retire;

   assign w_fill_ok  = i_fill_valid && r_pend[i_fill_tag] && !r_filled[i_fill_tag];
   assign o_ret_valid = r_pend[r_ret_ptr] && r_filled[r_ret_ptr];
   assign w_retire   = o_ret_valid && i_ret_ready;

   // Data storage is not reset; the output mux hides stale contents.
   assign o_ret_data  = o_ret_valid ? r_data[r_ret_ptr] : '0;
   assign o_ret_tag   = r_ret_ptr;
   assign o_alloc_ptr = r_alloc_ptr;
   assign o_occ       = r_occ;
   assign o_full      = (r_occ == (TAG_BITS+1)'(NUM_TAGS));
   assign o_err       = r_err;

   always_ff @(posedge clk) begin
      if (w_fill_ok) begin
         r_data[i_fill_tag] <= i_fill_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_filled    <= '0;
         r_alloc_ptr <= '0;
         r_ret_ptr   <= '0;
         r_occ       <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_retire) begin
            r_pend[r_ret_ptr]   <= 1'b0;
            r_filled[r_ret_ptr] <= 1'b0;
            r_ret_ptr           <= r_ret_ptr + TAG_BITS'(1);
         end
         if (w_fill_ok) begin
            r_filled[i_fill_tag] <= 1'b1;
         end else if (i_fill_valid) begin
            r_err <= 1'b1;
         end
         // Alloc can only hit ret_ptr when the buffer is empty, so it never collides with a retire.
         if (i_alloc) begin
            r_pend[r_alloc_ptr]   <= 1'b1;
            r_filled[r_alloc_ptr] <= 1'b0;
            r_alloc_ptr           <= r_alloc_ptr + TAG_BITS'(1);
         end
         case ({i_alloc, w_retire})
            2'b10:   r_occ <= r_occ + (TAG_BITS+1)'(1);
            2'b01:   r_occ <= r_occ - (TAG_BITS+1)'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: rtl/tc_mra_req_queue.sv
// Tile-controller to MRA request queue: registers and tags requests, returns responses in order.
// Define TC_MRA_PERF_CNT_EN to add saturating perf_issued / perf_stall / perf_max_occ outputs.
module tc_mra_req_queue
   import tc_pkg::*;
#(
   parameter  int ADDR_WIDTH = TC_MRA_ADDR_WIDTH,
   parameter  int DATA_WIDTH = TC_MRA_DATA_WIDTH,
   parameter  int NUM_TAGS   = TC_MRA_NUM_TAGS,
   localparam int TAG_BITS   = $clog2(NUM_TAGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_we,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  mra_req_valid,
   input  logic                  mra_req_ready,
   output logic [ADDR_WIDTH-1:0] mra_req_addr,
   output logic                  mra_req_we,
   output logic [DATA_WIDTH-1:0] mra_req_wdata,
   output logic [TAG_BITS-1:0]   mra_req_tag,
   input  logic                  mra_rsp_valid,
   input  logic [TAG_BITS-1:0]   mra_rsp_tag,
   input  logic [DATA_WIDTH-1:0] mra_rsp_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [TAG_BITS-1:0]   rsp_tag,
   output logic                  idle,
   output logic                  err
`ifdef TC_MRA_PERF_CNT_EN
  ,output logic [31:0]           perf_issued,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_max_occ
`endif
);

   logic                  r_live;
   logic                  r_req_valid;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [TAG_BITS-1:0]   r_tag;

   logic                  w_full;
   logic                  w_accept;
   logic                  w_issue;
   logic [TAG_BITS-1:0]   w_alloc_ptr;
   logic [TAG_BITS:0]     w_occ;

   // r_live keeps req_ready/idle low while reset is asserted, then high from the first clock after.
   assign req_ready = r_live && !w_full && (!r_req_valid || mra_req_ready);
   assign w_accept  = req_valid && req_ready;
   assign w_issue   = r_req_valid && mra_req_ready;
   assign idle      = r_live && (w_occ == '0) && !r_req_valid;

   assign mra_req_valid = r_req_valid;
   assign mra_req_addr  = r_addr;
   assign mra_req_we    = r_we;
   assign mra_req_wdata = r_wdata;
   assign mra_req_tag   = r_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live      <= 1'b0;
         r_req_valid <= 1'b0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_tag       <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_req_valid <= 1'b1;
            r_addr      <= req_addr;
            r_we        <= req_we;
            r_wdata     <= req_wdata;
            r_tag       <= w_alloc_ptr;
         end else if (mra_req_ready) begin
            r_req_valid <= 1'b0;
         end
      end
   end

   tc_mra_rob #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_TAGS   (NUM_TAGS)
   ) u_rob (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_alloc      (w_accept),
      .o_alloc_ptr  (w_alloc_ptr),
      .i_fill_valid (mra_rsp_valid),
      .i_fill_tag   (mra_rsp_tag),
      .i_fill_data  (mra_rsp_data),
      .o_ret_valid  (rsp_valid),
      .o_ret_data   (rsp_data),
      .o_ret_tag    (rsp_tag),
      .i_ret_ready  (rsp_ready),
      .o_occ        (w_occ),
      .o_full       (w_full),
      .o_err        (err)
   );

`ifdef TC_MRA_PERF_CNT_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_max_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_issued  <= '0;
         r_perf_stall   <= '0;
         r_perf_max_occ <= '0;
      end else begin
         if (w_issue) begin
            r_perf_issued <= tc_sat_inc32(r_perf_issued);
         end
         if (req_valid && !req_ready) begin
            r_perf_stall <= tc_sat_inc32(r_perf_stall);
         end
         if (32'(w_occ) > r_perf_max_occ) begin
            r_perf_max_occ <= 32'(w_occ);
         end
      end
   end

   assign perf_issued  = r_perf_issued;
   assign perf_stall   = r_perf_stall;
   assign perf_max_occ = r_perf_max_occ;
`else
   logic w_unused_issue;
   assign w_unused_issue = w_issue;
`endif

endmodule

// File: tb/tb_tc_mra_req_queue.sv
// Scoreboard bench for tc_mra_req_queue: directed stimulus, expectations queued at issue time,
// a negedge monitor compares every MRA and tc_fsm handshake against the queues.
module tb_tc_mra_req_queue;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [63:0]  req_addr;
   logic         req_we;
   logic [511:0] req_wdata;
   logic         mra_req_valid;
   logic         mra_req_ready;
   logic [63:0]  mra_req_addr;
   logic         mra_req_we;
   logic [511:0] mra_req_wdata;
   logic [2:0]   mra_req_tag;
   logic         mra_rsp_valid;
   logic [2:0]   mra_rsp_tag;
   logic [511:0] mra_rsp_data;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [511:0] rsp_data;
   logic [2:0]   rsp_tag;
   logic         idle;
   logic         err;
`ifdef TC_MRA_PERF_CNT_EN
   logic [31:0]  perf_issued;
   logic [31:0]  perf_stall;
   logic [31:0]  perf_max_occ;
`endif

   tc_mra_req_queue dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_we        (req_we),
      .req_wdata     (req_wdata),
      .mra_req_valid (mra_req_valid),
      .mra_req_ready (mra_req_ready),
      .mra_req_addr  (mra_req_addr),
      .mra_req_we    (mra_req_we),
      .mra_req_wdata (mra_req_wdata),
      .mra_req_tag   (mra_req_tag),
      .mra_rsp_valid (mra_rsp_valid),
      .mra_rsp_tag   (mra_rsp_tag),
      .mra_rsp_data  (mra_rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_tag       (rsp_tag),
      .idle          (idle),
      .err           (err)
`ifdef TC_MRA_PERF_CNT_EN
     ,.perf_issued   (perf_issued),
      .perf_stall    (perf_stall),
      .perf_max_occ  (perf_max_occ)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]  addr;
      logic         we;
      logic [511:0] wdata;
      logic [2:0]   tag;
   } mra_exp_t;

   mra_exp_t     exp_mra [$];
   logic [2:0]   exp_rsp [$];
   logic [511:0] exp_data [8];
   logic [2:0]   m_alloc;
   int           n_pass;
   int           n_total;

   mra_exp_t     mon_e;
   logic [2:0]   mon_t;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && mra_req_valid && mra_req_ready) begin
         if (exp_mra.size() == 0) begin
            n_total++;
            $display("FAIL mra_unexpected: got handshake tag %0d expected none", mra_req_tag);
         end else begin
            mon_e = exp_mra.pop_front();
            chk("mra_addr", mra_req_addr, mon_e.addr);
            chk("mra_we", mra_req_we, mon_e.we);
            chk("mra_tag", mra_req_tag, mon_e.tag);
            if (mon_e.we) chk("mra_wdata", mra_req_wdata, mon_e.wdata);
         end
      end
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) begin
            n_total++;
            $display("FAIL rsp_unexpected: got rsp tag %0d expected none", rsp_tag);
         end else begin
            mon_t = exp_rsp.pop_front();
            chk("rsp_tag", rsp_tag, mon_t);
            chk("rsp_data", rsp_data, exp_data[mon_t]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] a, input logic w, input logic [511:0] d);
      mra_exp_t e;
      e.addr  = a;
      e.we    = w;
      e.wdata = d;
      e.tag   = m_alloc;
      exp_mra.push_back(e);
      exp_rsp.push_back(m_alloc);
      m_alloc = m_alloc + 3'd1;
   endtask

   task automatic send(input logic [63:0] a, input logic w, input logic [511:0] d);
      int n;
      req_valid = 1'b1;
      req_addr  = a;
      req_we    = w;
      req_wdata = d;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         n_total++;
         $display("FAIL send_timeout: got req_ready 0 expected 1 within 50 cycles");
         req_valid = 1'b0;
         return;
      end
      push_exp(a, w, d);
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic respond(input logic [2:0] t, input logic [511:0] d);
      mra_rsp_valid = 1'b1;
      mra_rsp_tag   = t;
      mra_rsp_data  = d;
      exp_data[t]   = d;
      cyc();
      mra_rsp_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      req_valid     = 1'b0;
      mra_rsp_valid = 1'b0;
      mra_req_ready = 1'b1;
      rsp_ready     = 1'b1;
      cyc();
      exp_mra.delete();
      exp_rsp.delete();
      m_alloc = 3'd0;
      rst_n   = 1'b1;
      cyc();
      cyc();
   endtask

   logic [63:0]  s_addr;
   logic [2:0]   s_tag;

   initial begin
      n_pass = 0;
      n_total = 0;
      m_alloc = 3'd0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      req_we = 1'b0;
      req_wdata = '0;
      mra_req_ready = 1'b1;
      mra_rsp_valid = 1'b0;
      mra_rsp_tag = '0;
      mra_rsp_data = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_data[i] = '0;

      // reset state
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_idle", idle, 0);
      chk("rst_mra_valid", mra_req_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err", err, 0);
      do_reset();
      @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_idle", idle, 1);
      cyc();

      // single read
      send(64'h1000, 1'b0, '0);
      @(negedge clk);
      chk("t1_mra_valid", mra_req_valid, 1);
      cyc();
      cyc();
      cyc();
      mra_rsp_valid = 1'b1;
      mra_rsp_tag   = 3'd0;
      mra_rsp_data  = 512'hAB;
      exp_data[0]   = 512'hAB;
      @(negedge clk);
      chk("t1_rsp_not_same_cycle", rsp_valid, 0);
      cyc();
      mra_rsp_valid = 1'b0;
      @(negedge clk);
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_data", rsp_data, 512'hAB);
      cyc();
      @(negedge clk);
      chk("t1_idle", idle, 1);
      cyc();

      // out-of-order responses 3,1,0,2
      do_reset();
      for (int i = 0; i < 4; i++) send(64'h2000 + 64'(i), 1'b0, '0);
      respond(3'd3, 512'h33);
      respond(3'd1, 512'h11);
      @(negedge clk);
      chk("t2_rsp_blocked", rsp_valid, 0);
      cyc();
      respond(3'd0, 512'h10);
      respond(3'd2, 512'h22);
      repeat (5) cyc();
      chk("t2_drained", exp_rsp.size(), 0);
      @(negedge clk);
      chk("t2_idle", idle, 1);
      cyc();

      // full at 8 outstanding, retire tag 0 frees a slot
      do_reset();
      for (int i = 0; i < 8; i++) send(64'h3000 + 64'(i), 1'b0, '0);
      @(negedge clk);
      chk("t3_full_ready", req_ready, 0);
      cyc();
      respond(3'd0, 512'hF0);
      @(negedge clk);
      chk("t3_retire_valid", rsp_valid, 1);
      chk("t3_no_bypass", req_ready, 0);
      cyc();
      @(negedge clk);
      chk("t3_ready_after_retire", req_ready, 1);
      cyc();
      send(64'h3100, 1'b0, '0);
      @(negedge clk);
      cyc();

      // MRA backpressure
      do_reset();
      mra_req_ready = 1'b0;
      send(64'h4000, 1'b0, '0);
      req_valid = 1'b1;
      req_addr  = 64'h4100;
      req_we    = 1'b0;
      req_wdata = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", mra_req_valid, 1);
         chk("t4_hold_addr", mra_req_addr, 64'h4000);
         chk("t4_hold_tag", mra_req_tag, 0);
         chk("t4_hold_ready", req_ready, 0);
         cyc();
      end
      mra_req_ready = 1'b1;
      @(negedge clk);
      chk("t4_release_ready", req_ready, 1);
      push_exp(64'h4100, 1'b0, '0);
      cyc();
      req_valid = 1'b0;
      repeat (2) cyc();
      chk("t4_mra_drained", exp_mra.size(), 0);

      // spurious and duplicate responses
      do_reset();
      respond(3'd5, 512'h55);
      @(negedge clk);
      chk("t5_err_set", err, 1);
      chk("t5_no_rsp", rsp_valid, 0);
      repeat (3) cyc();
      @(negedge clk);
      chk("t5_err_sticky", err, 1);
      cyc();
      do_reset();
      @(negedge clk);
      chk("t5_err_cleared", err, 0);
      cyc();
      send(64'h5000, 1'b0, '0);
      cyc();
      respond(3'd0, 512'h77);
      respond(3'd0, 512'h77);
      @(negedge clk);
      chk("t5_dup_err", err, 1);
      cyc();

      // asynchronous reset mid-stream
      do_reset();
      for (int i = 0; i < 3; i++) send(64'h6000 + 64'(i), 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_mra_valid", mra_req_valid, 0);
      chk("t6_async_mra_addr", mra_req_addr, 0);
      chk("t6_async_req_ready", req_ready, 0);
      chk("t6_async_idle", idle, 0);
      chk("t6_async_rsp_valid", rsp_valid, 0);
      cyc();
      exp_mra.delete();
      exp_rsp.delete();
      m_alloc = 3'd0;
      rst_n = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      chk("t6_idle", idle, 1);
      chk("t6_req_ready", req_ready, 1);
      cyc();
      send(64'h6100, 1'b1, 512'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
      cyc();
      respond(3'd0, 512'hC0FFEE);
      repeat (3) cyc();
      @(negedge clk);
      chk("t6_final_idle", idle, 1);
      chk("t6_rsp_drained", exp_rsp.size(), 0);
      chk("t6_mra_drained", exp_mra.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tc_mra_req_queue.md
Name: tc_mra_req_queue

Overview:
- Sits between tc_fsm and the MRA (L1-to-MRA request / MRA-to-L1 response path).
- Registers tile-controller memory requests, tags them, and issues them to the MRA with valid/ready backpressure.
- Responses may return out of order; they are held in a reorder buffer and returned to tc_fsm strictly in issue order.
- Caps the number of outstanding MRA transactions at NUM_TAGS.

Parameters:
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 512, read/write data width
- NUM_TAGS, 8, reorder-buffer entries and maximum outstanding requests; power of 2, at least 2
- TAG_BITS, $clog2(NUM_TAGS), tag width (derived localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  tc_fsm request valid
- req_ready  out  1  queue can accept a request
- req_addr  in  ADDR_WIDTH  request address
- req_we  in  1  1 = write, 0 = read
- req_wdata  in  DATA_WIDTH  write data
- mra_req_valid  out  1  request valid to MRA
- mra_req_ready  in  1  MRA accepts request
- mra_req_addr  out  ADDR_WIDTH  registered address
- mra_req_we  out  1  registered write enable
- mra_req_wdata  out  DATA_WIDTH  registered write data
- mra_req_tag  out  TAG_BITS  tag of issued request
- mra_rsp_valid  in  1  MRA response valid; always accepted, no ready
- mra_rsp_tag  in  TAG_BITS  response tag
- mra_rsp_data  in  DATA_WIDTH  read data; ignored for writes
- rsp_valid  out  1  in-order response valid to tc_fsm
- rsp_ready  in  1  tc_fsm accepts response
- rsp_data  out  DATA_WIDTH  response data
- rsp_tag  out  TAG_BITS  tag of returned response
- idle  out  1  nothing outstanding and output register empty
- err  out  1  sticky spurious or duplicate response flag

Behaviour:
- Reset: one clock; rst_n is an asynchronous, active-low reset.
  - All outputs reset to 0 except req_ready and idle, which read 1 once out of reset.
  - alloc_ptr, ret_ptr and occ reset to 0; all ROB pend/filled bits cleared.
  - Assertion mid-operation discards all outstanding state; no response is replayed.
- Occupancy:
  - occ (TAG_BITS+1 bits) counts allocated, not-yet-retired entries.
  - full = (occ == NUM_TAGS), taken from the registered occ. No same-cycle retire bypass into req_ready.
- req_ready = !full && (!mra_req_valid || mra_req_ready).
- Accept (req_valid && req_ready):
  - Output register loads addr, we, wdata, and tag = alloc_ptr; mra_req_valid = 1 the next cycle. Latency is 1 cycle.
  - ROB[alloc_ptr]: pend = 1, filled = 0.
  - alloc_ptr increments, wrapping mod NUM_TAGS.
- Issue: mra_req_valid deasserts after an mra_req_ready handshake with no new accept that cycle. Outputs stay stable while valid && !ready.
- MRA response: every request, read or write, receives exactly one response.
  - If pend[tag] && !filled[tag]: data is stored and filled is set.
  - Otherwise: err is set (sticky until reset) and the ROB is unchanged.
- Retire:
  - rsp_valid = pend[ret_ptr] && filled[ret_ptr].
  - rsp_data and rsp_tag are read from entry ret_ptr.
  - A response arriving in cycle N is presented no earlier than cycle N+1.
  - On rsp_valid && rsp_ready: entry cleared, ret_ptr increments (wraps), occ decrements.
- Simultaneous events:
  - Accept and retire in the same cycle: occ unchanged.
  - MRA fill and retire of different entries in the same cycle are both honoured.
  - A fill to the entry being retired cannot occur, because retire requires filled.
- idle = (occ == 0) && !mra_req_valid.

Optional Feature:
- Macro: TC_MRA_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_issued (MRA handshakes), perf_stall (cycles with req_valid && !req_ready) and perf_max_occ (high-water mark of occ).
  - All saturate at max and clear on reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tc_pkg holds:
  - TC_MRA_NUM_TAGS default
  - typedef tc_mra_tag_t
  - struct tc_mra_req_t {addr, we, wdata, tag}
  - struct tc_rob_entry_t {pend, filled, data}
- Natural sub-module: tc_mra_rob (tag storage, fill, in-order retire, occ). The top holds the issue register and handshakes.

Test Plan:
- Single read of 0x1000 accepted at cycle 0:
  - mra_req_valid=1, tag=0 at cycle 1.
  - Response tag 0, data 0xAB at cycle 4 → rsp_valid=1, rsp_data=0xAB at cycle 5; idle=1 after retire.
- Reads tags 0..3 with responses in tag order 3,1,0,2 → rsp_tag sequence 0,1,2,3 with matching data; rsp_valid=0 until tag 0 is filled.
- NUM_TAGS=8: 8 reads accepted with no responses → req_ready=0.
  - Fill and retire tag 0 → req_ready=1 the cycle after retire; next request gets tag 0.
- mra_req_ready held low 5 cycles with a pending request → mra_req_* stable, req_ready=0, alloc_ptr unchanged.
- Response tag 5 while idle → err=1 and stays 1; rsp_valid=0. rst_n pulse → err=0.
- 3 outstanding, rst_n low mid-stream → all outputs 0 asynchronously; after release idle=1, req_ready=1, next tag=0.
